// File: rtl/cdc_fifo_wr_arbiter_pkg.sv
// Shared types and constants for the CDC FIFO write arbiter.
// The optional beat statistics counter is enabled by defining CDC_ARB_STATS_EN.
package cdc_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int STATS_W = 16;

   // Index width that stays legal even for a single-entry vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdc_fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle for cdc_fifo_wr_arbiter.
// master = arbiter side, slave = requesters plus FIFO side.
interface cdc_fifo_wr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int SLOTS = 8
) ();

   localparam int GW  = cdc_arb_pkg::idx_w(N_REQ);
   localparam int OCW = $clog2(SLOTS) + 1;

   logic [N_REQ-1:0]            req_valid_i;
   logic [N_REQ-1:0][WIDTH-1:0] req_data_i;
   logic [N_REQ-1:0]            req_ready_o;
   logic                        fifo_full_i;
   logic [OCW-1:0]              fifo_ocup_i;
   logic                        fifo_wr_en_o;
   logic [WIDTH-1:0]            fifo_wr_data_o;
   logic [GW-1:0]               grant_o;
   logic                        busy_o;

   modport master (
      input  req_valid_i, req_data_i, fifo_full_i, fifo_ocup_i,
      output req_ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o, busy_o
   );

   modport slave (
      output req_valid_i, req_data_i, fifo_full_i, fifo_ocup_i,
      input  req_ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o, busy_o
   );

endinterface

// File: rtl/cdc_fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after the
// last owner, wrapping from N_REQ-1 back to 0 (so the last owner comes last).
module cdc_rr_picker #(
   parameter int N_REQ = 4,
   parameter int GW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [GW-1:0]    last,
   output logic [GW-1:0]    winner,
   output logic             any
);

   logic found;
   int   idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = (int'(last) + i) % N_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = GW'(idx);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/cdc_fifo_wr_arbiter.sv
// Burst write arbiter in front of the write side of a CDC FIFO.
// Optional feature: CDC_ARB_STATS_EN adds the saturating beat counter wr_cnt_o.
module cdc_fifo_wr_arbiter
   import cdc_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int SLOTS     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                clk_wr,
   input  logic                arst_wr,
`ifdef CDC_ARB_STATS_EN
   output logic [STATS_W-1:0]  wr_cnt_o,
`endif
   cdc_fifo_wr_arbiter_if.master bus
);

   localparam int GW  = idx_w(N_REQ);
   localparam int OCW = $clog2(SLOTS) + 1;
   localparam int BW  = $clog2(MAX_BURST + 1);

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_q, last_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [GW-1:0] winner;
   logic          any_valid;
   logic          owner_valid;
   logic          beat;
   logic          room_ok;

   cdc_rr_picker #(
      .N_REQ (N_REQ),
      .GW    (GW)
   ) u_picker (
      .req    (bus.req_valid_i),
      .last   (last_q),
      .winner (winner),
      .any    (any_valid)
   );

   // A new grant needs room for a whole burst; a running burst ignores occupancy.
   assign room_ok     = (bus.fifo_ocup_i <= OCW'(SLOTS - MAX_BURST));
   assign owner_valid = bus.req_valid_i[grant_q];
   assign beat        = (state_q == BURST) && owner_valid && !bus.fifo_full_i;

   always_ff @(posedge clk_wr or posedge arst_wr) begin
      if (arst_wr) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(N_REQ - 1);
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (any_valid && room_ok) begin
               state_d = BURST;
               grant_d = winner;
               beat_d  = '0;
            end
         end
         BURST: begin
            if (beat) begin
               beat_d = beat_q + BW'(1);
            end
            if (!owner_valid || (beat && (beat_q == BW'(MAX_BURST - 1)))) begin
               state_d = IDLE;
               last_d  = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs depend only on the async-reset state, so reset silences them at once.
   always_comb begin
      bus.req_ready_o    = '0;
      bus.fifo_wr_data_o = '0;
      if (state_q == BURST) begin
         bus.req_ready_o[grant_q] = ~bus.fifo_full_i;
         bus.fifo_wr_data_o       = bus.req_data_i[grant_q];
      end
   end

   assign bus.fifo_wr_en_o = beat;
   assign bus.busy_o       = (state_q == BURST);
   assign bus.grant_o      = grant_q;

`ifdef CDC_ARB_STATS_EN
   logic [STATS_W-1:0] wr_cnt_q;

   always_ff @(posedge clk_wr or posedge arst_wr) begin
      if (arst_wr) begin
         wr_cnt_q <= '0;
      end else if (beat && (wr_cnt_q != '1)) begin
         wr_cnt_q <= wr_cnt_q + STATS_W'(1);
      end
   end

   assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Directed bench for cdc_fifo_wr_arbiter (N_REQ=4, WIDTH=8, SLOTS=8, MAX_BURST=4).
// Define CDC_ARB_STATS_EN to also exercise the saturating beat counter.
module tb_cdc_fifo_wr_arbiter;
   import cdc_arb_pkg::*;

   localparam int N_REQ     = 4;
   localparam int WIDTH     = 8;
   localparam int SLOTS     = 8;
   localparam int MAX_BURST = 4;

   logic clk_wr  = 1'b0;
   logic arst_wr = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   cdc_fifo_wr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .SLOTS(SLOTS)) bus ();

`ifdef CDC_ARB_STATS_EN
   logic [STATS_W-1:0] wr_cnt;
`endif

   cdc_fifo_wr_arbiter #(
      .N_REQ     (N_REQ),
      .WIDTH     (WIDTH),
      .SLOTS     (SLOTS),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk_wr   (clk_wr),
      .arst_wr  (arst_wr),
`ifdef CDC_ARB_STATS_EN
      .wr_cnt_o (wr_cnt),
`endif
      .bus      (bus)
   );

   always #5 clk_wr = ~clk_wr;

   // {busy, wr_en, ready[3:0], grant[1:0]}
   function automatic logic [7:0] snap();
      return {bus.busy_o, bus.fifo_wr_en_o, bus.req_ready_o, bus.grant_o};
   endfunction

   task automatic tick();
      @(posedge clk_wr);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      arst_wr         = 1'b1;
      bus.req_valid_i = '0;
      bus.fifo_full_i = 1'b0;
      bus.fifo_ocup_i = '0;
      for (int i = 0; i < N_REQ; i++) bus.req_data_i[i] = 8'hA0 + 8'(i);
      tick();
      tick();
      obs = snap();
      total++;
      if (obs !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_state got=%b exp=%b", obs, 8'h00);
      end
      arst_wr = 1'b0;
      tick();
      obs = snap();
      total++;
      if (obs[7:2] !== 6'b0) begin
         bad++;
         $display("[TB] FAIL reset_release got=%b exp=000000", obs[7:2]);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] obs, exp;
      bus.req_valid_i = 4'hF;
      #1;
      for (int r = 0; r < N_REQ; r++) begin
         obs = snap();
         total++;
         if (obs[7:2] !== 6'b0) begin
            bad++;
            $display("[TB] FAIL rr_idle r=%0d got=%b exp=000000", r, obs[7:2]);
         end
         tick();
         for (int k = 0; k < MAX_BURST; k++) begin
            obs = snap();
            exp = {1'b1, 1'b1, 4'(1 << r), 2'(r)};
            total++;
            if (obs !== exp) begin
               bad++;
               $display("[TB] FAIL rr_beat r=%0d k=%0d got=%b exp=%b", r, k, obs, exp);
            end
            total++;
            if (bus.fifo_wr_data_o !== 8'hA0 + 8'(r)) begin
               bad++;
               $display("[TB] FAIL rr_data r=%0d got=%h exp=%h", r, bus.fifo_wr_data_o, 8'hA0 + 8'(r));
            end
            tick();
         end
      end
      bus.req_valid_i = '0;
      tick();
   endtask

   task automatic test_single_requester();
      logic [7:0] obs;
      int         sent;
      int         len;
      sent            = 0;
      bus.req_valid_i = 4'b0100;
      #1;
      for (int b = 0; b < 3; b++) begin
         len = (b == 2) ? 2 : 4;
         obs = snap();
         total++;
         if (obs[7:2] !== 6'b0) begin
            bad++;
            $display("[TB] FAIL single_idle b=%0d got=%b exp=000000", b, obs[7:2]);
         end
         tick();
         for (int k = 0; k < len; k++) begin
            obs = snap();
            total++;
            if (obs !== 8'b11_0100_10) begin
               bad++;
               $display("[TB] FAIL single_beat b=%0d k=%0d got=%b exp=%b", b, k, obs, 8'b11_0100_10);
            end
            tick();
            sent++;
         end
      end
      bus.req_valid_i = '0;
      #1;
      obs = snap();
      total++;
      if (obs !== 8'b10_0100_10) begin
         bad++;
         $display("[TB] FAIL single_drop got=%b exp=%b", obs, 8'b10_0100_10);
      end
      tick();
      obs = snap();
      total++;
      if (obs[7:2] !== 6'b0 || sent != 10) begin
         bad++;
         $display("[TB] FAIL single_exit got=%b sent=%0d exp=000000 sent=10", obs[7:2], sent);
      end
   endtask

   task automatic test_full_stall();
      logic [7:0] obs;
      bus.req_valid_i = 4'b0010;
      #1;
      tick();
      for (int k = 0; k < 2; k++) begin
         obs = snap();
         total++;
         if (obs !== 8'b11_0010_01) begin
            bad++;
            $display("[TB] FAIL stall_pre k=%0d got=%b exp=%b", k, obs, 8'b11_0010_01);
         end
         tick();
      end
      bus.fifo_full_i = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         obs = snap();
         total++;
         if (obs !== 8'b10_0000_01) begin
            bad++;
            $display("[TB] FAIL stall_full k=%0d got=%b exp=%b", k, obs, 8'b10_0000_01);
         end
         tick();
      end
      bus.fifo_full_i = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         obs = snap();
         total++;
         if (obs !== 8'b11_0010_01) begin
            bad++;
            $display("[TB] FAIL stall_post k=%0d got=%b exp=%b", k, obs, 8'b11_0010_01);
         end
         tick();
      end
      obs = snap();
      total++;
      if (obs[7:2] !== 6'b0) begin
         bad++;
         $display("[TB] FAIL stall_exit got=%b exp=000000", obs[7:2]);
      end
      bus.req_valid_i = '0;
      tick();
   endtask

   task automatic test_occupancy();
      logic [7:0] obs;
      bus.req_valid_i = 4'b0001;
      bus.fifo_ocup_i = 4'd5;
      #1;
      for (int k = 0; k < 3; k++) begin
         obs = snap();
         total++;
         if (obs[7:2] !== 6'b0) begin
            bad++;
            $display("[TB] FAIL ocup_block k=%0d got=%b exp=000000", k, obs[7:2]);
         end
         tick();
      end
      bus.fifo_ocup_i = 4'd4;
      #1;
      tick();
      obs = snap();
      total++;
      if (obs !== 8'b11_0001_00) begin
         bad++;
         $display("[TB] FAIL ocup_grant got=%b exp=%b", obs, 8'b11_0001_00);
      end
      bus.fifo_ocup_i = 4'd7;
      #1;
      obs = snap();
      total++;
      if (obs !== 8'b11_0001_00) begin
         bad++;
         $display("[TB] FAIL ocup_continue got=%b exp=%b", obs, 8'b11_0001_00);
      end
      bus.req_valid_i = '0;
      bus.fifo_ocup_i = '0;
      #1;
      obs = snap();
      total++;
      if (obs !== 8'b10_0001_00) begin
         bad++;
         $display("[TB] FAIL ocup_drop got=%b exp=%b", obs, 8'b10_0001_00);
      end
      tick();
      obs = snap();
      total++;
      if (obs[7:2] !== 6'b0) begin
         bad++;
         $display("[TB] FAIL ocup_exit got=%b exp=000000", obs[7:2]);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] obs;
      bus.req_valid_i = 4'b1000;
      #1;
      tick();
      obs = snap();
      total++;
      if (obs !== 8'b11_1000_11) begin
         bad++;
         $display("[TB] FAIL rst_beat1 got=%b exp=%b", obs, 8'b11_1000_11);
      end
      tick();
      arst_wr = 1'b1;
      #1;
      obs = snap();
      total++;
      if (obs !== 8'h00) begin
         bad++;
         $display("[TB] FAIL rst_mid got=%b exp=%b", obs, 8'h00);
      end
      tick();
      arst_wr         = 1'b0;
      bus.req_valid_i = 4'b1001;
      #1;
      tick();
      obs = snap();
      total++;
      if (obs !== 8'b11_0001_00) begin
         bad++;
         $display("[TB] FAIL rst_regrant got=%b exp=%b", obs, 8'b11_0001_00);
      end
      bus.req_valid_i = '0;
      tick();
      tick();
   endtask

`ifdef CDC_ARB_STATS_EN
   task automatic test_stats();
      arst_wr = 1'b1;
      #1;
      total++;
      if (wr_cnt !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL stats_reset got=%h exp=0000", wr_cnt);
      end
      tick();
      arst_wr         = 1'b0;
      bus.req_valid_i = 4'b0001;
      #1;
      for (int k = 0; k < 5; k++) tick();
      total++;
      if (wr_cnt !== 16'd4) begin
         bad++;
         $display("[TB] FAIL stats_one_burst got=%h exp=0004", wr_cnt);
      end
      for (int k = 0; k < 16384 * 5; k++) tick();
      total++;
      if (wr_cnt !== 16'hFFFF) begin
         bad++;
         $display("[TB] FAIL stats_saturate got=%h exp=ffff", wr_cnt);
      end
      bus.req_valid_i = '0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single_requester();
      test_full_stall();
      test_occupancy();
      test_reset_mid_burst();
`ifdef CDC_ARB_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
